error_log_arbiter: RTL and testbench

- Sequences and shares the error-log RAM, a 1024-entry associative address/error store with separate write and read ports, between N_REQ error reporters and one lookup client.
- Round-robin arbitrates reporter writes, one write per cycle, onto the RAM write port.
- Runs a small read FSM that issues lookups, waits out RAM latency and returns the result.
- Forwards a same-cycle write to the same address, filters reserved address 0, and keeps saturating statistics.

---
 rtl/error_log_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_error_log_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/error_log_arbiter.sv
// -----------------------------------------------------------------------------
// error_log_arbiter
//
// Shares the error-log RAM between N_REQ error reporters (write side) and one
// lookup client (read side).
//   * Reporters are round-robin arbitrated, one accept per cycle. An accepted
//     record is issued on the RAM write port the following cycle. Records for
//     the reserved address 0 are accepted but dropped.
//   * Lookups run through a four-state FSM (IDLE/ISSUE/WAIT/RESP) that covers
//     the one-cycle RAM read latency. A write to the same address in the ISSUE
//     cycle would make the RAM return stale data, so that write is forwarded.
//   * Saturating counters track issued writes and dropped records.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   rep_valid/rep_ready            per-reporter handshake (ready is one-hot/zero)
//   rep_addr/rep_err               packed reporter records, slot i at [i*W +: W]
//   rd_req/rd_ready/rd_addr        lookup request handshake
//   rd_valid/rd_data               one-cycle lookup result (0 = not found)
//   ram_we/ram_waddr/ram_werr      RAM write port
//   ram_re/ram_raddr/ram_rerr      RAM read port (ram_rerr one cycle after ram_re)
//   stat_clr                       synchronous clear of both counters
//   wr_count/drop_count            saturating statistics
// -----------------------------------------------------------------------------
module error_log_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int ERR_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        rep_valid,
    output logic [N_REQ-1:0]        rep_ready,
    input  logic [N_REQ*ADDR_W-1:0] rep_addr,
    input  logic [N_REQ*ERR_W-1:0]  rep_err,
    input  logic                    rd_req,
    output logic                    rd_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [ERR_W-1:0]        rd_data,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_waddr,
    output logic [ERR_W-1:0]        ram_werr,
    output logic                    ram_re,
    output logic [ADDR_W-1:0]       ram_raddr,
    input  logic [ERR_W-1:0]        ram_rerr,
    input  logic                    stat_clr,
    output logic [CNT_W-1:0]        wr_count,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } rd_state_t;

    // ---------------------------------------------------------------------
    // Round-robin grant
    // ---------------------------------------------------------------------
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [ERR_W-1:0]  sel_err;
    logic              wr_inc;
    logic              drop_inc;

    always_comb begin
        int idx;
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Search upward from the pointer, wrapping, and take the first valid.
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && rep_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign rep_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    assign sel_addr  = rep_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_err   = rep_err[grant_idx*ERR_W +: ERR_W];

    // Address 0 is reserved: the record is consumed but never written.
    assign wr_inc    = grant_any && (sel_addr != '0);
    assign drop_inc  = grant_any && (sel_addr == '0);

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating statistics; a clear in the same cycle as an increment wins.
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] wr_count_q,   wr_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    always_comb begin
        wr_count_d   = wr_count_q;
        drop_count_d = drop_count_q;
        if (stat_clr) begin
            wr_count_d   = '0;
            drop_count_d = '0;
        end else begin
            if (wr_inc && (wr_count_q != '1))     wr_count_d   = wr_count_q + 1'b1;
            if (drop_inc && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Write issue stage
    // ---------------------------------------------------------------------
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_waddr_q;
    logic [ERR_W-1:0]  ram_werr_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_waddr_q  <= '0;
            ram_werr_q   <= '0;
            wr_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            ram_we_q     <= wr_inc;
            wr_count_q   <= wr_count_d;
            drop_count_q <= drop_count_d;
            if (wr_inc) begin
                ram_waddr_q <= sel_addr;
                ram_werr_q  <= sel_err;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read FSM
    // ---------------------------------------------------------------------
    rd_state_t         state_q;
    logic              ram_re_q;
    logic [ADDR_W-1:0] ram_raddr_q;
    logic              fwd_q;
    logic [ERR_W-1:0]  fwd_err_q;
    logic              rd_valid_q;
    logic [ERR_W-1:0]  rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ram_re_q    <= 1'b0;
            ram_raddr_q <= '0;
            fwd_q       <= 1'b0;
            fwd_err_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        state_q     <= S_ISSUE;
                        ram_re_q    <= 1'b1;
                        ram_raddr_q <= rd_addr;
                    end
                end
                S_ISSUE: begin
                    // A write landing on the same address this cycle is not
                    // visible in the RAM read data, so keep its value aside.
                    ram_re_q  <= 1'b0;
                    fwd_q     <= ram_we_q && (ram_waddr_q == ram_raddr_q);
                    fwd_err_q <= ram_werr_q;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    rd_data_q  <= fwd_q ? fwd_err_q : ram_rerr;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    rd_valid_q <= 1'b0;
                    fwd_q      <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_ready   = (state_q == S_IDLE);
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_werr   = ram_werr_q;
    assign ram_re     = ram_re_q;
    assign ram_raddr  = ram_raddr_q;
    assign wr_count   = wr_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_error_log_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for error_log_arbiter. A tiny RAM model answers lookups
// with a one-cycle registered read (0x200 holds 0x3A, everything else 0; it is
// never updated by writes, so same-cycle forwarding is observable).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there too (registered ones) or 1 more unit later (combinational ready).
// -----------------------------------------------------------------------------
module tb_error_log_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 32;
    localparam int ERR_W  = 10;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        rep_valid;
    logic [N_REQ-1:0]        rep_ready;
    logic [N_REQ*ADDR_W-1:0] rep_addr;
    logic [N_REQ*ERR_W-1:0]  rep_err;
    logic                    rd_req;
    logic                    rd_ready;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    rd_valid;
    logic [ERR_W-1:0]        rd_data;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [ERR_W-1:0]        ram_werr;
    logic                    ram_re;
    logic [ADDR_W-1:0]       ram_raddr;
    logic [ERR_W-1:0]        ram_rerr;
    logic                    stat_clr;
    logic [CNT_W-1:0]        wr_count;
    logic [CNT_W-1:0]        drop_count;

    int checks   = 0;
    int failures = 0;

    error_log_arbiter #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .ERR_W (ERR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rep_valid (rep_valid),
        .rep_ready (rep_ready),
        .rep_addr  (rep_addr),
        .rep_err   (rep_err),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_werr  (ram_werr),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rerr  (ram_rerr),
        .stat_clr  (stat_clr),
        .wr_count  (wr_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model with fixed contents.
    always @(posedge clk) begin
        if (ram_re) ram_rerr <= (ram_raddr == 32'h200) ? 10'h03A : 10'h000;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input int i, input logic [ADDR_W-1:0] a, input logic [ERR_W-1:0] e);
        rep_addr[i*ADDR_W +: ADDR_W] = a;
        rep_err[i*ERR_W +: ERR_W]    = e;
    endtask

    task automatic default_recs;
        for (int i = 0; i < N_REQ; i++) set_rec(i, ADDR_W'(32'h10 + i), ERR_W'(i + 1));
    endtask

    initial begin
        rst       = 1'b1;
        rep_valid = '0;
        rep_addr  = '0;
        rep_err   = '0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        stat_clr  = 1'b0;
        ram_rerr  = '0;
        default_recs();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_rep_ready", 64'(rep_ready), 64'h0);
        check("rst_ram_we", 64'(ram_we), 64'h0);
        check("rst_ram_re", 64'(ram_re), 64'h0);
        check("rst_rd_valid", 64'(rd_valid), 64'h0);
        check("rst_wr_count", 64'(wr_count), 64'h0);
        rst = 1'b0;

        // ---------------- round-robin, all valid for 8 cycles ----------------
        rep_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check($sformatf("rr_grant_%0d", c), 64'(rep_ready), 64'(4'b0001 << (c % 4)));
            if (c > 0) begin
                check($sformatf("rr_we_%0d", c), 64'(ram_we), 64'h1);
                check($sformatf("rr_waddr_%0d", c), 64'(ram_waddr), 64'(32'h10 + ((c - 1) % 4)));
            end else begin
                check("rr_we_first", 64'(ram_we), 64'h0);
            end
            tick();
        end
        rep_valid = '0;
        check("rr_we_last", 64'(ram_we), 64'h1);
        check("rr_waddr_last", 64'(ram_waddr), 64'h13);
        check("rr_wr_count", 64'(wr_count), 64'd8);
        tick();
        check("rr_we_off", 64'(ram_we), 64'h0);

        // ---------------- single reporter 2 ----------------
        set_rec(2, 32'h100, 10'h05);
        rep_valid = 4'b0100;
        #1;
        check("one_grant", 64'(rep_ready), 64'b0100);
        tick();
        check("one_we", 64'(ram_we), 64'h1);
        check("one_waddr", 64'(ram_waddr), 64'h100);
        check("one_werr", 64'(ram_werr), 64'h05);
        // Pointer now at 3: with all valid, reporter 3 wins.
        rep_valid = 4'hF;
        #1;
        check("ptr_is_3", 64'(rep_ready), 64'b1000);
        tick();
        check("ptr3_waddr", 64'(ram_waddr), 64'h13);

        // ---------------- address-0 drop ----------------
        set_rec(1, 32'h0, 10'h07);
        rep_valid = 4'b0010;
        #1;
        check("drop_grant", 64'(rep_ready), 64'b0010);
        tick();
        rep_valid = '0;
        default_recs();
        check("drop_no_we", 64'(ram_we), 64'h0);
        check("drop_count", 64'(drop_count), 64'd1);
        check("drop_wr_count", 64'(wr_count), 64'd10);

        // ---------------- lookup of 0x200 ----------------
        rd_req  = 1'b1;
        rd_addr = 32'h200;
        #1;
        check("rd_ready_idle", 64'(rd_ready), 64'h1);
        tick();
        rd_req = 1'b0;
        check("rd_t1_re", 64'(ram_re), 64'h1);
        check("rd_t1_raddr", 64'(ram_raddr), 64'h200);
        check("rd_t1_ready", 64'(rd_ready), 64'h0);
        check("rd_t1_valid", 64'(rd_valid), 64'h0);
        tick();
        check("rd_t2_re", 64'(ram_re), 64'h0);
        check("rd_t2_ready", 64'(rd_ready), 64'h0);
        check("rd_t2_valid", 64'(rd_valid), 64'h0);
        tick();
        check("rd_t3_valid", 64'(rd_valid), 64'h1);
        check("rd_t3_data", 64'(rd_data), 64'h3A);
        check("rd_t3_ready", 64'(rd_ready), 64'h0);
        tick();
        check("rd_t4_valid", 64'(rd_valid), 64'h0);
        check("rd_t4_ready", 64'(rd_ready), 64'h1);

        // ---------------- forwarding: write and read of 0x300 together -------
        // Pointer is at 2 after the address-0 record from reporter 1.
        set_rec(2, 32'h300, 10'h11);
        rep_valid = 4'b0100;
        rd_req    = 1'b1;
        rd_addr   = 32'h300;
        #1;
        check("fwd_grant", 64'(rep_ready), 64'b0100);
        check("fwd_rd_ready", 64'(rd_ready), 64'h1);
        tick();
        rep_valid = '0;
        rd_req    = 1'b0;
        default_recs();
        check("fwd_we", 64'(ram_we), 64'h1);
        check("fwd_re", 64'(ram_re), 64'h1);
        tick();
        tick();
        check("fwd_valid", 64'(rd_valid), 64'h1);
        check("fwd_data", 64'(rd_data), 64'h11);
        check("fwd_wr_count", 64'(wr_count), 64'd11);
        tick();

        // ---------------- reset during WAIT ----------------
        rd_req  = 1'b1;
        rd_addr = 32'h200;
        tick();
        rd_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rd_valid), 64'h0);
        check("mid_rst_data", 64'(rd_data), 64'h0);
        check("mid_rst_re", 64'(ram_re), 64'h0);
        check("mid_rst_raddr", 64'(ram_raddr), 64'h0);
        check("mid_rst_wr_count", 64'(wr_count), 64'h0);
        check("mid_rst_drop", 64'(drop_count), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("post_rst_valid_%0d", c), 64'(rd_valid), 64'h0);
            check($sformatf("post_rst_ready_%0d", c), 64'(rd_ready), 64'h1);
            tick();
        end

        // ---------------- stat_clr against a concurrent write ----------------
        rep_valid = 4'b0001;
        tick();
        check("clr_pre_count", 64'(wr_count), 64'd1);
        stat_clr = 1'b1;
        tick();
        rep_valid = '0;
        stat_clr  = 1'b0;
        check("clr_wins", 64'(wr_count), 64'd0);
        check("clr_write_issued", 64'(ram_we), 64'h1);
        tick();
        check("clr_hold", 64'(wr_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
